// File: rtl/nios_timer_ctrl.sv
// Avalon-MM master that programs, services, stops and snapshots an Altera/Nios interval timer.
// Timeouts come from timer_irq (USE_IRQ=1) or from polling the status register (USE_IRQ=0).
module nios_timer_ctrl #(
  parameter int USE_IRQ       = 1,
  parameter int POLL_INTERVAL = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic [31:0] cmd_period,
  input  logic        cmd_continuous,
  input  logic        cmd_stop,
  input  logic        cmd_snap,
  output logic        busy,
  output logic        timeout_pulse,
  output logic [15:0] timeout_count,
  output logic        snap_valid,
  output logic [31:0] snap_value,
  output logic [2:0]  av_address,
  output logic        av_chipselect,
  output logic        av_write_n,
  output logic [15:0] av_writedata,
  input  logic [15:0] av_readdata,
  input  logic        timer_irq
);

  localparam logic       IRQ_MODE    = (USE_IRQ != 0);
  localparam logic [7:0] POLL_LOAD   = 8'(POLL_INTERVAL - 1);
  localparam logic [2:0] ADDR_STATUS = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_PL     = 3'd2;
  localparam logic [2:0] ADDR_PH     = 3'd3;
  localparam logic [2:0] ADDR_SNAPL  = 3'd4;
  localparam logic [2:0] ADDR_SNAPH  = 3'd5;

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTRL, RUN, POLL_WAIT, POLL_RD, POLL_CHK,
    CLR_ST, WR_STOP, SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP
  } state_t;

  state_t      state, state_next;
  logic [31:0] period_q;
  logic        cont_q;
  logic        snap_ret_run;
  logic [15:0] snap_lo;
  logic [31:0] snap_q;
  logic [7:0]  poll_cnt;

  // Control state: FSM, mode flags, timeout counter and held snapshot
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cont_q        <= 1'b0;
      snap_ret_run  <= 1'b0;
      timeout_count <= '0;
      snap_q        <= '0;
    end else begin
      state <= state_next;
      if (state_next == WR_PL) begin
        cont_q        <= cmd_continuous;
        timeout_count <= '0;
      end else if (state_next == CLR_ST) begin
        // counted on entry so the pulse cycle already shows the new total
        timeout_count <= timeout_count + 16'd1;
      end
      if (state_next == SNAP_WR && state != SNAP_WR)
        snap_ret_run <= (state != IDLE);
      if (state == SNAP_CAP)
        snap_q <= {av_readdata, snap_lo};
    end
  end

  // Datapath registers; only meaningful once the owning sequence has started
  always_ff @(posedge clk) begin
    if (state_next == WR_PL)
      period_q <= cmd_period;
    if (state == SNAP_RD_H)
      snap_lo <= av_readdata;
    if (state == RUN)
      poll_cnt <= POLL_LOAD;
    else if (state == POLL_WAIT && poll_cnt != 8'd0)
      poll_cnt <= poll_cnt - 8'd1;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_start)     state_next = WR_PL;
        else if (cmd_snap) state_next = SNAP_WR;
      end
      WR_PL:   state_next = WR_PH;
      WR_PH:   state_next = WR_CTRL;
      WR_CTRL: state_next = RUN;
      RUN: begin
        // stop beats timeout beats snapshot; losers are dropped
        if (cmd_stop)                   state_next = WR_STOP;
        else if (IRQ_MODE && timer_irq) state_next = CLR_ST;
        else if (cmd_snap)              state_next = SNAP_WR;
        else if (!IRQ_MODE)             state_next = POLL_WAIT;
      end
      POLL_WAIT: begin
        if (cmd_stop)               state_next = WR_STOP;
        else if (cmd_snap)          state_next = SNAP_WR;
        else if (poll_cnt == 8'd0)  state_next = POLL_RD;
      end
      POLL_RD:   state_next = POLL_CHK;
      POLL_CHK:  state_next = av_readdata[0] ? CLR_ST : RUN;
      CLR_ST:    state_next = cont_q ? RUN : IDLE;
      WR_STOP:   state_next = IDLE;
      SNAP_WR:   state_next = SNAP_RD_L;
      SNAP_RD_L: state_next = SNAP_RD_H;
      SNAP_RD_H: state_next = SNAP_CAP;
      SNAP_CAP:  state_next = snap_ret_run ? RUN : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Bus outputs decode straight from the registered state; reset forces the idle pattern
  always_comb begin
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_address    = 3'd0;
    av_writedata  = 16'd0;
    if (!reset) begin
      case (state)
        WR_PL: begin
          av_chipselect = 1'b1; av_write_n = 1'b0;
          av_address = ADDR_PL; av_writedata = period_q[15:0];
        end
        WR_PH: begin
          av_chipselect = 1'b1; av_write_n = 1'b0;
          av_address = ADDR_PH; av_writedata = period_q[31:16];
        end
        WR_CTRL: begin
          av_chipselect = 1'b1; av_write_n = 1'b0;
          av_address = ADDR_CTRL;
          av_writedata = {12'b0, 1'b0, 1'b1, cont_q, IRQ_MODE};
        end
        CLR_ST: begin
          av_chipselect = 1'b1; av_write_n = 1'b0;
          av_address = ADDR_STATUS;
        end
        WR_STOP: begin
          av_chipselect = 1'b1; av_write_n = 1'b0;
          av_address = ADDR_CTRL; av_writedata = 16'h0008;
        end
        SNAP_WR: begin
          av_chipselect = 1'b1; av_write_n = 1'b0;
          av_address = ADDR_SNAPL;
        end
        POLL_RD: begin
          av_chipselect = 1'b1; av_address = ADDR_STATUS;
        end
        SNAP_RD_L: begin
          av_chipselect = 1'b1; av_address = ADDR_SNAPL;
        end
        SNAP_RD_H: begin
          av_chipselect = 1'b1; av_address = ADDR_SNAPH;
        end
        default: ;
      endcase
    end
  end

  assign busy          = !reset && (state != IDLE);
  assign timeout_pulse = !reset && (state == CLR_ST);
  assign snap_valid    = !reset && (state == SNAP_CAP);
  // high half arrives in the strobe cycle, so present it live and hold it afterwards
  assign snap_value    = snap_valid ? {av_readdata, snap_lo} : snap_q;

endmodule
